// File: rtl/fifo_seq_checker_pkg.sv
// fifo_seq_checker_pkg: shared FSM type, default widths and sequence helper for fifo_seq_checker.
package fifo_seq_checker_pkg;
  typedef enum logic {S_SEED, S_TRACK} state_t;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W = 16;
  localparam int SEQ_MAX_W = 64;
  function automatic logic [SEQ_MAX_W-1:0] next_seq(input logic [SEQ_MAX_W-1:0] x);
    return x + SEQ_MAX_W'(1);
  endfunction
endpackage

// File: rtl/fifo_seq_checker_sat_counter.sv
// sat_counter: up-counter with synchronous clear that either saturates or wraps at all ones.
module sat_counter #(
  parameter int W = 16,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_o = cnt_q;
  always_comb cnt_d = clr_i ? '0 : (inc_i && !(SAT && &cnt_q)) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
endmodule

// File: rtl/fifo_seq_checker.sv
// fifo_seq_checker: pops the FIFO read side and checks the words form a contiguous +1 sequence.
// Define FIFO_SEQ_CHECKER_CAPTURE_EN to add cap_expected/cap_actual holding the first mismatch.
module fifo_seq_checker
  import fifo_seq_checker_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic              rd_empty,
  output logic              rd_en,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] data_q,
  output logic              locked,
  output logic              err,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  word_count
`ifdef FIFO_SEQ_CHECKER_CAPTURE_EN
  ,
  output logic [DATA_W-1:0] cap_expected,
  output logic [DATA_W-1:0] cap_actual
`endif
);
  state_t state_q, state_d;
  logic [RD_LATENCY-1:0] pipe_q;
  logic [DATA_W-1:0] data_d, exp_w;
  logic locked_q, locked_d, err_q, err_d, sticky_q, sticky_d, vld, take, mis;
  assign rd_en = rst_n & enable & ~rd_empty;
  assign vld = pipe_q[RD_LATENCY-1];
  // clear wins over a coincident valid word, which is simply dropped
  assign take = vld & ~clear;
  assign exp_w = DATA_W'(next_seq(SEQ_MAX_W'(data_q)));
  assign mis = take && state_q == S_TRACK && dout != exp_w;
  assign locked = locked_q;
  assign err = err_q;
  assign err_sticky = sticky_q;
  always_comb begin
    state_d = clear ? S_SEED : take ? S_TRACK : state_q;
    data_d = take ? dout : data_q;
    locked_d = !clear && (locked_q || take);
    err_d = clear ? 1'b0 : take ? mis : err_q;
    sticky_d = !clear && (sticky_q || mis);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= S_SEED;
      pipe_q <= '0;
      data_q <= '1;
      locked_q <= 1'b0;
      err_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pipe_q <= RD_LATENCY'({pipe_q, rd_en});
      data_q <= data_d;
      locked_q <= locked_d;
      err_q <= err_d;
      sticky_q <= sticky_d;
    end
  sat_counter #(.W(CNT_W), .SAT(1'b1)) u_err_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(clear), .inc_i(mis), .cnt_o(err_count)
  );
  sat_counter #(.W(CNT_W), .SAT(1'b0)) u_word_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(clear), .inc_i(take), .cnt_o(word_count)
  );
`ifdef FIFO_SEQ_CHECKER_CAPTURE_EN
  // the sticky flag doubles as "first mismatch already captured"
  always_ff @(posedge clk)
    if (!rst_n || clear) begin
      cap_expected <= '0;
      cap_actual <= '0;
    end else if (mis && !sticky_q) begin
      cap_expected <= exp_w;
      cap_actual <= dout;
    end
`endif
endmodule

// File: tb/tb_fifo_seq_checker.sv
// tb_fifo_seq_checker: scoreboard bench driving two checkers, (CNT_W=16, RD_LATENCY=1) and (CNT_W=4, RD_LATENCY=2),
// from FIFO models fed with identical word streams.
module tb_fifo_seq_checker;
  typedef logic [31:0] wq_t[$];
  typedef struct packed {logic [31:0] d; logic e; logic s; logic [15:0] ec; logic [15:0] wc;} exp_t;
  typedef exp_t eq_t[$];
  logic clk = 1'b0;
  logic rst_n, enable, clear, hold;
  logic rd_empty[2], rd_en[2], locked[2], err[2], err_sticky[2];
  logic [31:0] dout[2], data_q[2];
  logic [15:0] ec0, wc0, ecv[2], wcv[2];
  logic [3:0] ec1, wc1;
`ifdef FIFO_SEQ_CHECKER_CAPTURE_EN
  logic [31:0] cap_e[2], cap_a[2];
`endif
  wq_t fifo[2];
  eq_t sb[2];
  logic [31:0] p1[2], p2[2], m_data[2];
  logic [2:0] c[2];
  bit m_lock[2], m_sticky[2], m_err[2];
  int m_ec[2], m_wc[2];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  assign ecv[0] = ec0;
  assign wcv[0] = wc0;
  assign ecv[1] = {12'd0, ec1};
  assign wcv[1] = {12'd0, wc1};
  fifo_seq_checker dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .rd_empty(rd_empty[0]), .rd_en(rd_en[0]),
    .dout(dout[0]), .data_q(data_q[0]), .locked(locked[0]), .err(err[0]), .err_sticky(err_sticky[0]),
    .err_count(ec0), .word_count(wc0)
`ifdef FIFO_SEQ_CHECKER_CAPTURE_EN
    , .cap_expected(cap_e[0]), .cap_actual(cap_a[0])
`endif
  );
  fifo_seq_checker #(.CNT_W(4), .RD_LATENCY(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .rd_empty(rd_empty[1]), .rd_en(rd_en[1]),
    .dout(dout[1]), .data_q(data_q[1]), .locked(locked[1]), .err(err[1]), .err_sticky(err_sticky[1]),
    .err_count(ec1), .word_count(wc1)
`ifdef FIFO_SEQ_CHECKER_CAPTURE_EN
    , .cap_expected(cap_e[1]), .cap_actual(cap_a[1])
`endif
  );
  task automatic reset_model(input int d);
    m_lock[d] = 1'b0;
    m_sticky[d] = 1'b0;
    m_err[d] = 1'b0;
    m_ec[d] = 0;
    m_wc[d] = 0;
  endtask
  // one clock: compare finished words at negedge, then emulate FIFO reads and predict new words
  task automatic cycle();
    bit take[2];
    bit rs, cl;
    exp_t e;
    logic [31:0] w;
    for (int d = 0; d < 2; d++) rd_empty[d] = hold || fifo[d].size() == 0;
    @(negedge clk);
    rs = rst_n;
    cl = clear;
    for (int d = 0; d < 2; d++) begin
      take[d] = rd_en[d];
      checks++;
      if (rd_en[d] && rd_empty[d]) begin
        failures++;
        $display("FAIL rd_en_while_empty dut%0d: rd_en=%b rd_empty=%b, want rd_en=0", d, rd_en[d], rd_empty[d]);
      end
      if (c[d][d+1]) begin
        checks++;
        if (sb[d].size() == 0) begin
          failures++;
          $display("FAIL sb_underflow dut%0d: DUT produced a word with none expected", d);
        end else begin
          e = sb[d].pop_front();
          if ({data_q[d], err[d], err_sticky[d], ecv[d], wcv[d], locked[d]} !== {e.d, e.e, e.s, e.ec, e.wc, 1'b1}) begin
            failures++;
            $display("FAIL word dut%0d: data_q=%h err=%b sticky=%b err_count=%0d word_count=%0d locked=%b, want %h %b %b %0d %0d 1",
                     d, data_q[d], err[d], err_sticky[d], ecv[d], wcv[d], locked[d], e.d, e.e, e.s, e.ec, e.wc);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      c[d] = rs ? {c[d][1:0], take[d]} : 3'b0;
      p2[d] = p1[d];
      if (!rs) begin
        sb[d].delete();
        reset_model(d);
      end else if (cl) reset_model(d);
      if (take[d]) begin
        w = fifo[d].size() != 0 ? fifo[d].pop_front() : 32'hDEAD_BEEF;
        p1[d] = w;
        if (m_lock[d]) begin
          m_err[d] = w != m_data[d] + 32'd1;
          if (m_err[d]) begin
            m_sticky[d] = 1'b1;
            if (m_ec[d] < (d == 0 ? 65535 : 15)) m_ec[d]++;
          end
        end
        m_lock[d] = 1'b1;
        m_data[d] = w;
        m_wc[d] = (m_wc[d] + 1) % (d == 0 ? 65536 : 16);
        sb[d].push_back('{w, m_err[d], m_sticky[d], 16'(m_ec[d]), 16'(m_wc[d])});
      end
      dout[d] = d == 0 ? p1[d] : p2[d];
      rd_empty[d] = hold || fifo[d].size() == 0;
    end
  endtask
  task automatic push(input logic [31:0] v);
    fifo[0].push_back(v);
    fifo[1].push_back(v);
  endtask
  task automatic drain();
    int n = 0;
    while (fifo[0].size() + fifo[1].size() + sb[0].size() + sb[1].size() != 0 || c[0] != 3'b0 || c[1] != 3'b0) begin
      cycle();
      n++;
      if (n > 2000) begin
        checks++;
        failures++;
        $display("FAIL drain_timeout: %0d/%0d words still queued after %0d cycles, want 0", fifo[0].size(), fifo[1].size(), n);
        break;
      end
    end
    cycle();
    cycle();
  endtask
  task automatic pulse_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cycle();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({data_q[d], locked[d], err[d], err_sticky[d], ecv[d], wcv[d]} !== {32'hFFFF_FFFF, 3'b000, 32'd0}) begin
        failures++;
        $display("FAIL reset_state dut%0d: data_q=%h locked=%b err=%b sticky=%b ec=%0d wc=%0d, want ffffffff 0 0 0 0 0",
                 d, data_q[d], locked[d], err[d], err_sticky[d], ecv[d], wcv[d]);
      end
    end
    rst_n = 1'b1;
  endtask
  task automatic test_stream();
    enable = 1'b0;
    for (int i = 0; i < 100; i++) push(i);
    cycle();
    checks++;
    if (fifo[0].size() != 100 || fifo[1].size() != 100) begin
      failures++;
      $display("FAIL enable_low_pop: fifo fill %0d/%0d, want 100/100", fifo[0].size(), fifo[1].size());
    end
    enable = 1'b1;
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({data_q[d], locked[d], err_sticky[d], ecv[d], wcv[d]} !== {32'd99, 2'b10, 16'd0, 16'(d == 0 ? 100 : 4)}) begin
        failures++;
        $display("FAIL stream_end dut%0d: data_q=%0d locked=%b sticky=%b ec=%0d wc=%0d, want 99 1 0 0 %0d",
                 d, data_q[d], locked[d], err_sticky[d], ecv[d], wcv[d], d == 0 ? 100 : 4);
      end
    end
  endtask
  task automatic test_gap();
    logic [31:0] seq [5] = '{32'd10, 32'd11, 32'd12, 32'd14, 32'd15};
    pulse_clear();
    foreach (seq[i]) push(seq[i]);
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({data_q[d], err[d], err_sticky[d], ecv[d], wcv[d]} !== {32'd15, 2'b01, 16'd1, 16'd5}) begin
        failures++;
        $display("FAIL gap_end dut%0d: data_q=%0d err=%b sticky=%b ec=%0d wc=%0d, want 15 0 1 1 5",
                 d, data_q[d], err[d], err_sticky[d], ecv[d], wcv[d]);
      end
    end
    push(32'd17);
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({err[d], err_sticky[d], ecv[d], wcv[d]} !== {2'b11, 16'd2, 16'd6}) begin
        failures++;
        $display("FAIL err_hold dut%0d: err=%b sticky=%b ec=%0d wc=%0d, want 1 1 2 6", d, err[d], err_sticky[d], ecv[d], wcv[d]);
      end
    end
  endtask
  task automatic test_wrap();
    logic [31:0] seq [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    pulse_clear();
    foreach (seq[i]) push(seq[i]);
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({data_q[d], err[d], err_sticky[d], ecv[d], wcv[d]} !== {32'd1, 2'b00, 16'd0, 16'd4}) begin
        failures++;
        $display("FAIL wrap dut%0d: data_q=%h err=%b sticky=%b ec=%0d wc=%0d, want 1 0 0 0 4",
                 d, data_q[d], err[d], err_sticky[d], ecv[d], wcv[d]);
      end
    end
  endtask
  task automatic test_saturate();
    pulse_clear();
    for (int i = 0; i < 20; i++) push(2 * i);
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({err[d], ecv[d], wcv[d]} !== {1'b1, 16'(d == 0 ? 19 : 15), 16'(d == 0 ? 20 : 4)}) begin
        failures++;
        $display("FAIL saturate dut%0d: err=%b ec=%0d wc=%0d, want 1 %0d %0d", d, err[d], ecv[d], wcv[d],
                 d == 0 ? 19 : 15, d == 0 ? 20 : 4);
      end
    end
  endtask
  task automatic test_back_to_back_toggle();
    pulse_clear();
    for (int i = 0; i < 50; i++) push(100 + i);
    for (int i = 0; i < 600 && fifo[0].size() + fifo[1].size() != 0; i++) begin
      hold = i % 2 == 1;
      enable = (i / 2) % 2 == 0;
      cycle();
    end
    hold = 1'b0;
    enable = 1'b1;
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({data_q[d], err_sticky[d], ecv[d], wcv[d]} !== {32'd149, 1'b0, 16'd0, 16'(d == 0 ? 50 : 2)}) begin
        failures++;
        $display("FAIL toggle dut%0d: data_q=%0d sticky=%b ec=%0d wc=%0d, want 149 0 0 %0d",
                 d, data_q[d], err_sticky[d], ecv[d], wcv[d], d == 0 ? 50 : 2);
      end
    end
  endtask
  task automatic test_mid_reset();
    int n = 0;
    pulse_clear();
    for (int i = 0; i < 60; i++) push(i < 6 ? i : i + 1);
    while (wc0 < 16'd37 && n < 500) begin
      cycle();
      n++;
    end
    checks++;
    if (wc0 < 16'd37) begin
      failures++;
      $display("FAIL reach_word37: word_count=%0d, want >=37", wc0);
    end
`ifdef FIFO_SEQ_CHECKER_CAPTURE_EN
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({cap_e[d], cap_a[d]} !== {32'd6, 32'd7}) begin
        failures++;
        $display("FAIL capture dut%0d: cap_expected=%0d cap_actual=%0d, want 6 7", d, cap_e[d], cap_a[d]);
      end
    end
`endif
    rst_n = 1'b0;
    cycle();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({data_q[d], locked[d], err[d], err_sticky[d], ecv[d], wcv[d]} !== {32'hFFFF_FFFF, 3'b000, 32'd0}) begin
        failures++;
        $display("FAIL mid_reset_state dut%0d: data_q=%h locked=%b err=%b sticky=%b ec=%0d wc=%0d, want ffffffff 0 0 0 0 0",
                 d, data_q[d], locked[d], err[d], err_sticky[d], ecv[d], wcv[d]);
      end
`ifdef FIFO_SEQ_CHECKER_CAPTURE_EN
      checks++;
      if ({cap_e[d], cap_a[d]} !== 64'd0) begin
        failures++;
        $display("FAIL capture_reset dut%0d: cap_expected=%0d cap_actual=%0d, want 0 0", d, cap_e[d], cap_a[d]);
      end
`endif
    end
    rst_n = 1'b1;
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({data_q[d], locked[d], err[d], err_sticky[d], ecv[d], wcv[d]} !== {32'd60, 3'b100, 16'd0, 16'(m_wc[d])}) begin
        failures++;
        $display("FAIL reseed dut%0d: data_q=%0d locked=%b err=%b sticky=%b ec=%0d wc=%0d, want 60 1 0 0 0 %0d",
                 d, data_q[d], locked[d], err[d], err_sticky[d], ecv[d], wcv[d], m_wc[d]);
      end
    end
  endtask
  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    clear = 1'b0;
    hold = 1'b0;
    for (int d = 0; d < 2; d++) begin
      c[d] = 3'b0;
      p1[d] = 32'd0;
      p2[d] = 32'd0;
      dout[d] = 32'd0;
      m_data[d] = 32'd0;
      rd_empty[d] = 1'b1;
      reset_model(d);
    end
    test_reset();
    test_stream();
    test_gap();
    test_wrap();
    test_saturate();
    test_back_to_back_toggle();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
